// File: rtl/decode_stage_pkg.sv
// Shared ALU operation encodings and decode constants.
package decode_stage_pkg;

  // Opcodes that get special immediate / write-position handling in decode.
  localparam logic [3:0] OPC_WRITE = 4'h8;
  localparam logic [3:0] OPC_LOAD  = 4'h9;
  localparam logic [3:0] OPC_JMP   = 4'hC;

  // rD write position: full word, low byte or high byte.
  localparam logic [1:0] WPOS_FULL = 2'd0;
  localparam logic [1:0] WPOS_LOW  = 2'd1;
  localparam logic [1:0] WPOS_HIGH = 2'd2;

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO with async active-high reset and synchronous flush.
// Storage is cleared on reset so the head reads as zero until the first push.
module decode_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_data  = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CntW'(1);
    end
  end

  // Entry storage; cleared on reset so no stale data is ever presented.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered instruction decoder: splits raw instructions into fields and queues
// the decoded result so fetch and execute can stall independently.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter  int unsigned OPC_W  = 4,
  parameter  int unsigned REG_W  = 3,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned INSN_W = OPC_W + 3 * REG_W + 3,
  localparam int unsigned IMM_W  = 2 * REG_W + 2
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_flush,
  input  logic              I_valid,
  input  logic [INSN_W-1:0] I_instruction,
  output logic              O_ready,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [OPC_W-1:0]  O_opcode,
  output logic [REG_W-1:0]  O_rD_select,
  output logic [REG_W-1:0]  O_rA_select,
  output logic [REG_W-1:0]  O_rB_select,
  output logic              O_mode,
  output logic [IMM_W-1:0]  O_immediate,
  output logic [1:0]        O_rD_write_pos
);

  localparam int unsigned ENT_W = OPC_W + 3 * REG_W + 1 + IMM_W + 2;
  localparam logic [OPC_W-1:0] OpcWrite = OPC_W'(OPC_WRITE);
  localparam logic [OPC_W-1:0] OpcLoad  = OPC_W'(OPC_LOAD);
  localparam logic [OPC_W-1:0] OpcJmp   = OPC_W'(OPC_JMP);

  logic [OPC_W-1:0] w_opcode;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic             w_mode;
  logic [1:0]       w_lo;
  logic [IMM_W-1:0] w_imm;
  logic [1:0]       w_wpos;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  // Layout, MSB to LSB: opcode | rD | mode | rA | rB | lo[1:0]
  assign w_opcode = I_instruction[INSN_W-1 -: OPC_W];
  assign w_rd     = I_instruction[3*REG_W+2 -: REG_W];
  assign w_mode   = I_instruction[2*REG_W+2];
  assign w_ra     = I_instruction[2*REG_W+1 -: REG_W];
  assign w_rb     = I_instruction[REG_W+1 -: REG_W];
  assign w_lo     = I_instruction[1:0];

  // Immediate formation and rD write position, chosen by opcode class.
  always_comb begin
    w_imm  = {{REG_W{w_rb[REG_W-1]}}, w_rb, w_lo};
    w_wpos = WPOS_FULL;
    if (w_opcode == OpcWrite) begin
      w_imm = {{REG_W{w_rd[REG_W-1]}}, w_rd, w_lo};
    end else if (w_opcode == OpcLoad || w_opcode == OpcJmp) begin
      w_imm  = {w_ra, w_rb, w_lo};
      w_wpos = w_mode ? WPOS_HIGH : WPOS_LOW;
    end
  end

  assign w_entry = {w_opcode, w_rd, w_ra, w_rb, w_mode, w_imm, w_wpos};

  // Ready depends only on registered occupancy, never on I_ready.
  assign O_ready = !w_full;
  assign O_valid = !w_empty;
  assign w_push  = I_valid && O_ready && !I_flush;
  assign w_pop   = O_valid && I_ready && !I_flush;

  decode_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (I_clk),
    .i_reset (I_reset),
    .i_flush (I_flush),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {O_opcode, O_rD_select, O_rA_select, O_rB_select, O_mode, O_immediate,
          O_rD_write_pos} = w_head;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: two decode_stage instances (defaults, and REG_W=4/DEPTH=4)
// driven in lockstep; each has its own expected-entry queue and occupancy model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] rd;
    logic       mode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] lo;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst, flush, valid, ready;
  logic [15:0] insn_a;
  logic [18:0] insn_b;

  logic       a_ready, a_valid, a_mode;
  logic [3:0] a_opc;
  logic [2:0] a_rd, a_ra, a_rb;
  logic [7:0] a_imm;
  logic [1:0] a_wpos;

  logic       b_ready, b_valid, b_mode;
  logic [3:0] b_opc;
  logic [3:0] b_rd, b_ra, b_rb;
  logic [9:0] b_imm;
  logic [1:0] b_wpos;

  logic [28:0] obs_a, obs_b;
  logic [28:0] q_a[$];
  logic [28:0] q_b[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage u_dut_a (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_valid(valid), .I_instruction(insn_a),
    .O_ready(a_ready), .O_valid(a_valid), .I_ready(ready), .O_opcode(a_opc),
    .O_rD_select(a_rd), .O_rA_select(a_ra), .O_rB_select(a_rb), .O_mode(a_mode),
    .O_immediate(a_imm), .O_rD_write_pos(a_wpos)
  );

  decode_stage #(.OPC_W(4), .REG_W(4), .DEPTH(4)) u_dut_b (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_valid(valid), .I_instruction(insn_b),
    .O_ready(b_ready), .O_valid(b_valid), .I_ready(ready), .O_opcode(b_opc),
    .O_rD_select(b_rd), .O_rA_select(b_ra), .O_rB_select(b_rb), .O_mode(b_mode),
    .O_immediate(b_imm), .O_rD_write_pos(b_wpos)
  );

  assign obs_a = {a_opc, 1'b0, a_rd, 1'b0, a_ra, 1'b0, a_rb, a_mode, 2'b00, a_imm, a_wpos};
  assign obs_b = {b_opc, b_rd, b_ra, b_rb, b_mode, b_imm, b_wpos};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] enc(input stim_t s, input int regw);
    if (regw == 3) return {3'b000, s.opc, s.rd[2:0], s.mode, s.ra[2:0], s.rb[2:0], s.lo};
    return {s.opc, s.rd, s.mode, s.ra, s.rb, s.lo};
  endfunction

  // Reference decode using integer arithmetic, fields zero-padded to 4 bits.
  function automatic logic [28:0] model(input stim_t s, input int regw);
    int mask, rd, ra, rb, lo, imm, wpos, immw;
    mask = (1 << regw) - 1;
    rd   = int'(s.rd) & mask;
    ra   = int'(s.ra) & mask;
    rb   = int'(s.rb) & mask;
    lo   = int'(s.lo);
    immw = 2 * regw + 2;
    wpos = 0;
    if (s.opc == OPC_WRITE) begin
      imm = rd * 4 + lo;
      if (imm >= (1 << (regw + 1))) imm = imm - (1 << (regw + 2));
    end else if (s.opc == OPC_LOAD || s.opc == OPC_JMP) begin
      imm  = (ra << (regw + 2)) + (rb << 2) + lo;
      wpos = s.mode ? 2 : 1;
    end else begin
      imm = rb * 4 + lo;
      if (imm >= (1 << (regw + 1))) imm = imm - (1 << (regw + 2));
    end
    imm = imm & ((1 << immw) - 1);
    return {s.opc, 4'(rd), 4'(ra), 4'(rb), s.mode, 10'(imm), 2'(wpos)};
  endfunction

  task automatic check_outputs();
    check_eq("a_ready", a_ready, q_a.size() < 2);
    check_eq("a_valid", a_valid, q_a.size() != 0);
    if (q_a.size() != 0) check_eq("a_head", obs_a, q_a[0]);
    check_eq("b_ready", b_ready, q_b.size() < 4);
    check_eq("b_valid", b_valid, q_b.size() != 0);
    if (q_b.size() != 0) check_eq("b_head", obs_b, q_b[0]);
  endtask

  // Drive one cycle of stimulus, advance the models across the edge, then check.
  task automatic step(input logic v, input logic rdy, input logic fl, input stim_t s);
    logic push_a, pop_a, push_b, pop_b;
    valid  = v;
    ready  = rdy;
    flush  = fl;
    insn_a = enc(s, 3)[15:0];
    insn_b = enc(s, 4);
    push_a = v && (q_a.size() < 2) && !fl;
    pop_a  = (q_a.size() != 0) && rdy && !fl;
    push_b = v && (q_b.size() < 4) && !fl;
    pop_b  = (q_b.size() != 0) && rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (pop_a) void'(q_a.pop_front());
      if (push_a) q_a.push_back(model(s, 3));
      if (pop_b) void'(q_b.pop_front());
      if (push_b) q_b.push_back(model(s, 4));
    end
    check_outputs();
  endtask

  task automatic check_reset_state();
    check_eq("a_rst_ready", a_ready, 1'b1);
    check_eq("a_rst_valid", a_valid, 1'b0);
    check_eq("a_rst_fields", obs_a, '0);
    check_eq("b_rst_ready", b_ready, 1'b1);
    check_eq("b_rst_valid", b_valid, 1'b0);
    check_eq("b_rst_fields", obs_b, '0);
  endtask

  initial begin
    stim_t s, sa, sb, sc;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0;
    insn_a = '0; insn_b = '0;
    #2;
    check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;

    // WRITE: rD=101, lo=10 -> 0xF6 at REG_W=3
    s = '{opc: OPC_WRITE, rd: 4'b0101, mode: 1'b0, ra: 4'd0, rb: 4'd0, lo: 2'b10};
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("write_imm", a_imm, 8'hF6);
    check_eq("write_wpos", a_wpos, 2'd0);
    check_eq("write_rd", a_rd, 3'd5);

    // LOAD/JMP back-to-back with a live consumer: one per cycle
    s = '{opc: OPC_LOAD, rd: 4'd1, mode: 1'b1, ra: 4'b0011, rb: 4'b0100, lo: 2'b01};
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("load_m1_imm", a_imm, 8'h71);
    check_eq("load_m1_wpos", a_wpos, 2'd2);
    s.mode = 1'b0;
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("load_m0_wpos", a_wpos, 2'd1);
    s.opc = OPC_JMP;
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("jmp_m0_imm", a_imm, 8'h71);
    check_eq("jmp_m0_wpos", a_wpos, 2'd1);
    s.mode = 1'b1;
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("jmp_m1_wpos", a_wpos, 2'd2);

    // Other opcodes: sign-extended {rB, lo}
    s = '{opc: 4'h1, rd: 4'd2, mode: 1'b0, ra: 4'd7, rb: 4'b0110, lo: 2'b11};
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("other_neg_imm", a_imm, 8'hFB);
    check_eq("other_wpos", a_wpos, 2'd0);
    s.rb = 4'b1010; s.lo = 2'b00;
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("other_pos_imm", a_imm, 8'h08);
    check_eq("b_other_neg_imm", b_imm, 10'h3E8);

    // Wide config sign extension from rD
    s = '{opc: OPC_WRITE, rd: 4'b1010, mode: 1'b0, ra: 4'd0, rb: 4'd0, lo: 2'b01};
    step(1'b1, 1'b1, 1'b0, s);
    check_eq("b_write_imm", b_imm, 10'h3E9);
    check_eq("a_write_pos_imm", a_imm, 8'h09);
    step(1'b0, 1'b1, 1'b0, s);

    // Backpressure: A, B accepted, C held by the depth-2 stage until a pop
    sa = '{opc: 4'h2, rd: 4'd1, mode: 1'b0, ra: 4'd1, rb: 4'd1, lo: 2'd1};
    sb = '{opc: 4'h3, rd: 4'd2, mode: 1'b1, ra: 4'd2, rb: 4'd2, lo: 2'd2};
    sc = '{opc: OPC_LOAD, rd: 4'd3, mode: 1'b1, ra: 4'd3, rb: 4'd3, lo: 2'd3};
    step(1'b1, 1'b0, 1'b0, sa);
    step(1'b1, 1'b0, 1'b0, sb);
    check_eq("bp_full_ready", a_ready, 1'b0);
    step(1'b1, 1'b0, 1'b0, sc);
    step(1'b1, 1'b1, 1'b0, sc);
    step(1'b1, 1'b1, 1'b0, sc);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, sc);

    // Flush with two entries buffered, new push and pop in the same cycle
    step(1'b1, 1'b0, 1'b0, sa);
    step(1'b1, 1'b0, 1'b0, sb);
    step(1'b1, 1'b1, 1'b1, sc);
    check_eq("flush_valid", a_valid, 1'b0);
    check_eq("flush_ready", a_ready, 1'b1);

    // Random traffic; exercises pointer wrap in both depths
    for (int i = 0; i < 400; i++) begin
      s.opc  = ($urandom % 3 == 0) ? OPC_LOAD + 4'($urandom % 4) : 4'($urandom);
      s.rd   = 4'($urandom);
      s.mode = 1'($urandom);
      s.ra   = 4'($urandom);
      s.rb   = 4'($urandom);
      s.lo   = 2'($urandom);
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 25) == 0, s);
    end

    // Asynchronous reset between edges with both buffers full
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, sa);
    #3 rst = 1'b1;
    #1;
    check_reset_state();
    q_a.delete();
    q_b.delete();
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, sc);
    step(1'b1, 1'b1, 1'b0, sb);
    step(1'b0, 1'b1, 1'b0, sb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
